// File: rtl/dmem_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines and
// a flush walker that writes every dirty line back to memory.
//  state   | meaning
//  IDLE    | accept a request or start a flush
//  LOOKUP  | tag compare against the registered array read
//  EVICT   | write the dirty victim back to memory
//  FILL    | fetch the missed word from memory
//  INSTALL | write tag/data, answer loads with the fill data
//  FL_SCAN | inspect the line at the flush index
//  FL_WB   | write back the dirty line at the flush index
module dmem_cache #(
    parameter int AddressWidth = 25,
    parameter int IndexWidth   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [31:0]             req_data,
    input  logic                    req_wr,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [31:0]             rsp_data,
    output logic                    rsp_valid,
    output logic [AddressWidth-1:0] mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    mem_we,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_rvalid,
    input  logic                    flush,
    output logic                    flush_done
);
    localparam int TagWidth = AddressWidth - IndexWidth;
    localparam int Lines    = 1 << IndexWidth;
    localparam logic [IndexWidth:0] FlLast = (IndexWidth + 1)'(Lines - 1);
    localparam logic [IndexWidth:0] FlStep = (IndexWidth + 1)'(1);

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, INSTALL, FL_SCAN, FL_WB} state_t;
    state_t state, state_nxt;

    logic [31:0]             data_mem [Lines];
    logic [TagWidth-1:0]     tag_mem  [Lines];
    logic [31:0]             data_q;
    logic [TagWidth-1:0]     tag_q;
    logic [Lines-1:0]        valid, dirty;
    logic [AddressWidth-1:0] lat_addr;
    logic [31:0]             lat_data;
    logic                    lat_rd;
    logic                    fill_acked;
    logic [31:0]             fill_data;
    logic [IndexWidth:0]     fl_idx;
    logic [IndexWidth-1:0]   rd_idx;
    logic                    hit, victim_dirty, fl_dirty, fl_last, accept;

    wire [IndexWidth-1:0] lat_idx = lat_addr[IndexWidth-1:0];
    wire [TagWidth-1:0]   lat_tag = lat_addr[AddressWidth-1:IndexWidth];
    wire [IndexWidth-1:0] fl_line = fl_idx[IndexWidth-1:0];

    assign hit          = valid[lat_idx] && (tag_q == lat_tag);
    assign victim_dirty = valid[lat_idx] && dirty[lat_idx];
    assign fl_dirty     = valid[fl_line] && dirty[fl_line];
    assign fl_last      = (fl_idx == FlLast);
    assign accept       = req_valid && req_ready;

    // The array read port follows whichever line the next state will inspect.
    always_comb begin
        if (state == IDLE)
            rd_idx = req_addr[IndexWidth-1:0];
        else if (state == FL_SCAN || state == FL_WB)
            rd_idx = fl_line;
        else
            rd_idx = lat_idx;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = data_q;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = lat_addr;
        mem_wdata  = data_q;
        flush_done = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~flush;
                if (flush)          state_nxt = FL_SCAN;
                else if (req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    rsp_valid = lat_rd;
                    state_nxt = IDLE;
                end else if (victim_dirty) begin
                    state_nxt = EVICT;
                end else begin
                    state_nxt = lat_rd ? FILL : INSTALL;
                end
            end
            EVICT: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q, lat_idx};
                if (mem_ready) state_nxt = lat_rd ? FILL : INSTALL;
            end
            FILL: begin
                mem_valid = ~fill_acked;
                if (fill_acked && mem_rvalid) state_nxt = INSTALL;
            end
            INSTALL: begin
                rsp_valid = lat_rd;
                rsp_data  = fill_data;
                state_nxt = IDLE;
            end
            FL_SCAN: begin
                if (fl_dirty) begin
                    state_nxt = FL_WB;
                end else if (fl_last) begin
                    flush_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            FL_WB: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q, fl_line};
                if (mem_ready) begin
                    flush_done = fl_last;
                    state_nxt  = fl_last ? IDLE : FL_SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset) begin
            req_ready  = 1'b0;
            rsp_valid  = 1'b0;
            mem_valid  = 1'b0;
            flush_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            fill_acked <= 1'b0;
            fl_idx     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_addr <= req_addr;
                lat_data <= req_data;
                lat_rd   <= req_wr;
            end
            case (state)
                IDLE: begin
                    fill_acked <= 1'b0;
                    if (flush) fl_idx <= '0;
                end
                LOOKUP: if (hit && !lat_rd) dirty[lat_idx] <= 1'b1;
                FILL: begin
                    if (mem_valid && mem_ready) fill_acked <= 1'b1;
                    if (fill_acked && mem_rvalid) fill_data <= mem_rdata;
                end
                INSTALL: begin
                    valid[lat_idx] <= 1'b1;
                    dirty[lat_idx] <= ~lat_rd;
                    fill_acked     <= 1'b0;
                end
                FL_SCAN: if (!fl_dirty) begin
                    valid[fl_line] <= 1'b0;
                    if (!fl_last) fl_idx <= fl_idx + FlStep;
                end
                FL_WB: if (mem_ready) begin
                    valid[fl_line] <= 1'b0;
                    dirty[fl_line] <= 1'b0;
                    if (!fl_last) fl_idx <= fl_idx + FlStep;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_mem[rd_idx];
        tag_q  <= tag_mem[rd_idx];
        if (reset && state == LOOKUP && hit && !lat_rd)
            data_mem[lat_idx] <= lat_data;
        if (reset && state == INSTALL) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= lat_rd ? fill_data : lat_data;
        end
    end
endmodule

// File: tb/tb_dmem_cache.sv
// Scoreboard bench for dmem_cache: directed requests push expected memory
// operations and load data; a negedge monitor pops and compares them.
module tb_dmem_cache;
    localparam int AW = 25;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic          req_wr, req_valid, req_ready;
    logic [31:0]   rsp_data;
    logic          rsp_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we, mem_valid, mem_ready, mem_rvalid;
    logic          flush, flush_done;

    always #5 clk = ~clk;

    dmem_cache #(.AddressWidth(AW), .IndexWidth(IW)) dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_data(req_data), .req_wr(req_wr),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .flush(flush), .flush_done(flush_done)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } mem_op_t;

    mem_op_t     exp_mem[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] mem_model [int];
    int checks = 0, errors = 0;
    int mem_count = 0, rsp_count = 0, flush_count = 0;
    int ready_delay = 0, rvalid_delay = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_mem_op(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        mem_op_t op;
        op.we = we; op.addr = a; op.wdata = d;
        exp_mem.push_back(op);
    endtask

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return {7'b0, a} ^ 32'h5A5A0000;
    endfunction

    // Monitor: a handshake seen at negedge completes at the following posedge.
    mem_op_t     mon_op;
    logic [31:0] mon_d;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (rsp_valid) begin
                rsp_count++;
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected got=%0h expected=none", rsp_data);
                end else begin
                    mon_d = exp_rsp.pop_front();
                    chk("rsp_data", rsp_data, mon_d);
                end
            end
            if (mem_valid && mem_ready) begin
                mem_count++;
                if (exp_mem.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected got=%0h expected=none", mem_addr);
                end else begin
                    mon_op = exp_mem.pop_front();
                    chk("mem_we", mem_we, mon_op.we);
                    chk("mem_addr", mem_addr, mon_op.addr);
                    if (mon_op.we) chk("mem_wdata", mem_wdata, mon_op.wdata);
                end
            end
            if (flush_done) flush_count++;
        end
    end

    // Memory responder: ready after ready_delay cycles, read data rvalid_delay later.
    logic          rst_neg = 1'b0;
    int            age = 0, rd_wait = 0;
    logic          rd_pend = 1'b0, hs, cur_we;
    logic [AW-1:0] rd_addr, cur_addr;
    logic [31:0]   cur_wdata;
    always @(negedge clk) rst_neg = reset;

    initial begin
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        cur_we = 0; cur_addr = 0; cur_wdata = 0; rd_addr = 0;
        forever begin
            @(posedge clk); #2;
            hs = mem_ready && rst_neg;
            mem_ready  = 0;
            mem_rvalid = 0;
            if (rd_pend) begin
                if (rd_wait == 0) begin
                    mem_rvalid = 1; mem_rdata = mem_rd(rd_addr); rd_pend = 0;
                end else rd_wait--;
            end
            if (hs) begin
                age = 0;
                if (cur_we) mem_model[int'(cur_addr)] = cur_wdata;
                else begin rd_pend = 1; rd_wait = rvalid_delay; rd_addr = cur_addr; end
            end
            if (mem_valid) begin
                if (age >= ready_delay) begin
                    mem_ready = 1; cur_we = mem_we; cur_addr = mem_addr; cur_wdata = mem_wdata;
                end else age++;
            end else age = 0;
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic [31:0] d, input logic rd);
        bit ok = 0;
        @(posedge clk); #1;
        req_addr = a; req_data = d; req_wr = rd; req_valid = 1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int m0, f0, r0, stalls, cyc;
    bit seen, stable, rdy_hi, done, ok;
    logic [AW-1:0] a0;
    logic [31:0] d0;

    initial begin
        reset = 0; req_addr = 0; req_data = 0; req_wr = 1; req_valid = 0; flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        @(posedge clk); #1 reset = 1;

        // clean read miss, then hit
        m0 = mem_count;
        exp_mem_op(0, 'h10, 0); exp_rsp.push_back(32'hDEADBEEF);
        mem_model[int'('h10)] = 32'hDEADBEEF;
        issue('h10, 0, 1);
        @(negedge clk); chk("miss_lookup_mem_valid", mem_valid, 0);
        @(negedge clk); chk("miss_fill_mem_valid", mem_valid, 1);
        chk("miss_fill_mem_addr", mem_addr, 'h10);
        wait_idle();
        chk("miss_mem_ops", mem_count - m0, 1);
        m0 = mem_count;
        exp_rsp.push_back(32'hDEADBEEF);
        issue('h10, 0, 1);
        @(negedge clk); chk("hit_rsp_valid_t1", rsp_valid, 1);
        @(negedge clk); chk("hit_req_ready_t2", req_ready, 1);
        #1 chk("hit_no_mem", mem_count - m0, 0);

        // clean write miss then read back
        issue('h20, 32'h12345678, 0);
        @(negedge clk); chk("wmiss_lookup_ready", req_ready, 0);
        @(negedge clk); chk("wmiss_install_ready", req_ready, 0);
        @(negedge clk); chk("wmiss_ready_t3", req_ready, 1);
        exp_rsp.push_back(32'h12345678);
        issue('h20, 0, 1);
        wait_idle();
        chk("wr_rd_no_mem", mem_count - m0, 0);

        // dirty eviction on a conflicting read, then refill of the victim
        issue('h30, 32'hAAAA0001, 0); wait_idle();
        m0 = mem_count;
        exp_mem_op(1, 'h30, 32'hAAAA0001); exp_mem_op(0, 'h430, 0);
        exp_rsp.push_back(32'h5A5A0430);
        issue('h430, 0, 1); wait_idle();
        chk("evict_mem_ops", mem_count - m0, 2);
        exp_mem_op(0, 'h30, 0); exp_rsp.push_back(32'hAAAA0001);
        issue('h30, 0, 1); wait_idle();

        // eviction with memory back-pressure
        issue('h40, 32'hBBBB0002, 0); wait_idle();
        ready_delay = 5;
        exp_mem_op(1, 'h40, 32'hBBBB0002); exp_mem_op(0, 'h440, 0);
        exp_rsp.push_back(32'h5A5A0440);
        issue('h440, 0, 1);
        seen = 0; stable = 1; stalls = 0; rdy_hi = 0; done = 0; a0 = 0; d0 = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (mem_valid && !seen) begin seen = 1; a0 = mem_addr; d0 = mem_wdata; end
            if (seen) begin
                if (mem_addr !== a0 || mem_wdata !== d0 || mem_we !== 1'b1) stable = 0;
                if (req_ready) rdy_hi = 1;
                if (!mem_ready) stalls++; else done = 1;
            end
        end
        chk("evict_seen", seen, 1);
        chk("evict_stable", stable, 1);
        chk("evict_stall_cycles", stalls, 5);
        chk("evict_req_ready_low", rdy_hi, 0);
        wait_idle();
        ready_delay = 0;

        // flush the one remaining dirty line (0x20)
        f0 = flush_count;
        exp_mem_op(1, 'h20, 32'h12345678);
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        wait_idle();
        chk("flush1_done", flush_count - f0, 1);

        // dirty lines at index 0, 5 and last; flush beats a same-cycle request
        issue('h400, 32'hC0000000, 0); wait_idle();
        issue('h805, 32'hC0000005, 0); wait_idle();
        issue('h3FF, 32'hC00003FF, 0); wait_idle();
        m0 = mem_count; f0 = flush_count;
        exp_mem_op(1, 'h400, 32'hC0000000);
        exp_mem_op(1, 'h805, 32'hC0000005);
        exp_mem_op(1, 'h3FF, 32'hC00003FF);
        @(posedge clk); #1;
        flush = 1; req_valid = 1; req_addr = 'h7; req_wr = 1;
        @(negedge clk); chk("flush_wins_ready", req_ready, 0);
        @(posedge clk); #1 flush = 0; req_valid = 0;
        wait_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("flush2_mem_writes", mem_count - m0, 3);
        chk("flush2_done_pulses", flush_count - f0, 1);
        m0 = mem_count;
        exp_mem_op(0, 'h400, 0); exp_rsp.push_back(32'hC0000000);
        issue('h400, 0, 1); wait_idle();
        exp_mem_op(0, 'h805, 0); exp_rsp.push_back(32'hC0000005);
        issue('h805, 0, 1); wait_idle();
        exp_mem_op(0, 'h3FF, 0); exp_rsp.push_back(32'hC00003FF);
        issue('h3FF, 0, 1); wait_idle();
        chk("post_flush_all_miss", mem_count - m0, 3);

        // flush with nothing dirty: one scan cycle per line
        m0 = mem_count;
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        cyc = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cyc++;
            if (flush_done) break;
        end
        chk("flush_clean_cycles", cyc, 1024);
        wait_idle();
        chk("flush_clean_no_mem", mem_count - m0, 0);

        // reset during FILL; late fill data must be ignored
        rvalid_delay = 4;
        r0 = rsp_count;
        exp_mem_op(0, 'h50, 0);
        issue('h50, 0, 1);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_valid && mem_ready) begin ok = 1; break; end
        end
        chk("fill_hs_seen", ok, 1);
        @(posedge clk); #1 reset = 0;
        @(negedge clk); chk("rst_mid_fill_mem_valid", mem_valid, 0);
        @(posedge clk); #1 reset = 1;
        @(negedge clk); chk("post_rst_mem_valid", mem_valid, 0);
        repeat (10) @(negedge clk);
        #1;
        chk("rst_fill_no_rsp", rsp_count - r0, 0);
        rvalid_delay = 0;
        m0 = mem_count;
        exp_mem_op(0, 'h50, 0); exp_rsp.push_back(32'h5A5A0050);
        issue('h50, 0, 1); wait_idle();
        chk("refetch_after_rst", mem_count - m0, 1);

        repeat (3) @(negedge clk);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        chk("mem_queue_empty", exp_mem.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
